// File: rtl/life_grid.sv
// life_grid: row-serial life-like cellular automaton engine.
// One row is rewritten per clock from old copies of its neighbours.
module life_grid #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int WRAP   = 1,
  parameter int GEN_W  = 16,
  localparam int POP_W = $clog2(WIDTH*HEIGHT+1),
  localparam int ROW_W = $clog2(HEIGHT)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_load,
  input  logic [ROW_W-1:0]        i_load_row,
  input  logic [WIDTH-1:0]        i_load_data,
  input  logic [8:0]              i_birth,
  input  logic [8:0]              i_survive,
  input  logic                    i_step,
  input  logic                    i_run,
  output logic [WIDTH*HEIGHT-1:0] o_grid,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [GEN_W-1:0]        o_generation,
  output logic [POP_W-1:0]        o_population,
  output logic                    o_stable
);

  typedef enum logic {IDLE, COMPUTE} state_t;

  localparam logic WRAP_B = (WRAP != 0);
  localparam logic [ROW_W-1:0] LAST = ROW_W'(HEIGHT-1);

  state_t state;
  logic [HEIGHT-1:0][WIDTH-1:0] rows;
  logic [WIDTH-1:0] row0_old;
  logic [WIDTH-1:0] prev_old;
  logic [ROW_W-1:0] row;
  logic [8:0] birth_q;
  logic [8:0] surv_q;
  logic chg;
  logic [POP_W-1:0] pop_acc;

  logic last;
  logic [ROW_W-1:0] nxt;
  logic [WIDTH-1:0] cur, above, below, new_row;
  logic [WIDTH-1:0] aw, ae, cw, ce, bw, be;
  logic [3:0] n;
  logic [POP_W-1:0] row_pop, load_pop;
  logic load_ok;
  logic row_chg;

  // Neighbour in column c-1 / c+1; edge columns wrap or read dead.
  function automatic logic [WIDTH-1:0] west(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], WRAP_B & v[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] east(input logic [WIDTH-1:0] v);
    return {WRAP_B & v[0], v[WIDTH-1:1]};
  endfunction

  assign o_grid  = rows;
  assign last    = (row == LAST);
  assign nxt     = last ? '0 : row + ROW_W'(1);
  assign cur     = rows[row];
  assign above   = prev_old;
  assign below   = last ? (WRAP_B ? row0_old : '0) : rows[nxt];
  assign load_ok = (i_load_row <= LAST);
  assign aw = west(above);
  assign ae = east(above);
  assign cw = west(cur);
  assign ce = east(cur);
  assign bw = west(below);
  assign be = east(below);
  assign row_chg = (new_row != cur);

  always_comb begin
    new_row = '0;
    row_pop = '0;
    n = '0;
    for (int c = 0; c < WIDTH; c++) begin
      n = 4'(aw[c]) + 4'(above[c]) + 4'(ae[c])
        + 4'(cw[c]) + 4'(ce[c])
        + 4'(bw[c]) + 4'(below[c]) + 4'(be[c]);
      new_row[c] = cur[c] ? surv_q[n] : birth_q[n];
      row_pop = row_pop + POP_W'(new_row[c]);
    end
  end

  // Population of the grid as it will look after this cycle's load.
  always_comb begin
    load_pop = '0;
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++)
        load_pop = load_pop + POP_W'(
          (load_ok && i_load_row == ROW_W'(r)) ?
          i_load_data[c] : rows[r][c]);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      rows         <= '0;
      row0_old     <= '0;
      prev_old     <= '0;
      row          <= '0;
      birth_q      <= '0;
      surv_q       <= '0;
      chg          <= 1'b0;
      pop_acc      <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_stable     <= 1'b0;
      o_generation <= '0;
      o_population <= '0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_load) begin
            if (load_ok) begin
              for (int r = 0; r < HEIGHT; r++)
                if (i_load_row == ROW_W'(r))
                  rows[r] <= i_load_data;
              o_population <= load_pop;
              o_stable     <= 1'b0;
            end
          end else if (i_step || i_run) begin
            birth_q  <= i_birth;
            surv_q   <= i_survive;
            row      <= '0;
            row0_old <= rows[0];
            prev_old <= WRAP_B ? rows[HEIGHT-1] : '0;
            chg      <= 1'b0;
            pop_acc  <= '0;
            o_busy   <= 1'b1;
            state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          rows[row] <= new_row;
          prev_old  <= cur;
          pop_acc   <= pop_acc + row_pop;
          chg       <= chg | row_chg;
          row       <= nxt;
          if (last) begin
            o_population <= pop_acc + row_pop;
            o_stable     <= !(chg | row_chg);
            o_generation <= o_generation + GEN_W'(1);
            o_done       <= 1'b1;
            o_busy       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_grid.sv
// tb_life_grid: directed checks of life_grid on 5x5 bounded and
// 8x8 toroidal/bounded grids.
module tb_life_grid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 5x5, bounded edges
  logic        a_rst, a_load, a_step, a_run;
  logic [2:0]  a_row;
  logic [4:0]  a_data;
  logic [8:0]  a_birth, a_surv;
  logic [24:0] a_grid;
  logic        a_busy, a_done, a_stable;
  logic [15:0] a_gen;
  logic [4:0]  a_pop;

  life_grid #(.WIDTH(5), .HEIGHT(5), .WRAP(0), .GEN_W(16)) u_a (
    .i_clk(clk), .i_reset(a_rst), .i_load(a_load),
    .i_load_row(a_row), .i_load_data(a_data),
    .i_birth(a_birth), .i_survive(a_surv),
    .i_step(a_step), .i_run(a_run),
    .o_grid(a_grid), .o_busy(a_busy), .o_done(a_done),
    .o_generation(a_gen), .o_population(a_pop),
    .o_stable(a_stable)
  );

  // 8x8 pair sharing stimulus: b toroidal, c bounded
  logic        g_rst, g_load, g_step, g_run;
  logic [2:0]  g_row;
  logic [7:0]  g_data;
  logic [8:0]  g_birth, g_surv;
  logic [63:0] b_grid, c_grid;
  logic        b_busy, b_done, b_stable;
  logic        c_busy, c_done, c_stable;
  logic [5:0]  b_gen, c_gen;
  logic [6:0]  b_pop, c_pop;

  life_grid #(.WIDTH(8), .HEIGHT(8), .WRAP(1), .GEN_W(6)) u_b (
    .i_clk(clk), .i_reset(g_rst), .i_load(g_load),
    .i_load_row(g_row), .i_load_data(g_data),
    .i_birth(g_birth), .i_survive(g_surv),
    .i_step(g_step), .i_run(g_run),
    .o_grid(b_grid), .o_busy(b_busy), .o_done(b_done),
    .o_generation(b_gen), .o_population(b_pop),
    .o_stable(b_stable)
  );

  life_grid #(.WIDTH(8), .HEIGHT(8), .WRAP(0), .GEN_W(6)) u_c (
    .i_clk(clk), .i_reset(g_rst), .i_load(g_load),
    .i_load_row(g_row), .i_load_data(g_data),
    .i_birth(g_birth), .i_survive(g_surv),
    .i_step(g_step), .i_run(g_run),
    .o_grid(c_grid), .o_busy(c_busy), .o_done(c_done),
    .o_generation(c_gen), .o_population(c_pop),
    .o_stable(c_stable)
  );

  function automatic logic [24:0] mk5(input logic [4:0] r0,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic [4:0] r3, input logic [4:0] r4);
    return {r4, r3, r2, r1, r0};
  endfunction

  task automatic a_load_row(input logic [2:0] r, input logic [4:0] d);
    a_load = 1'b1;
    a_row  = r;
    a_data = d;
    @(negedge clk);
    a_load = 1'b0;
  endtask

  task automatic a_set(input logic [24:0] gr);
    for (int r = 0; r < 5; r++)
      a_load_row(3'(r), gr[r*5 +: 5]);
  endtask

  task automatic a_wait_done(output int lat);
    lat = 1;
    while (!a_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic a_step_wait(output int lat);
    a_step = 1'b1;
    @(negedge clk);
    a_step = 1'b0;
    a_wait_done(lat);
  endtask

  task automatic g_set(input logic [63:0] gr);
    for (int r = 0; r < 8; r++) begin
      g_load = 1'b1;
      g_row  = 3'(r);
      g_data = gr[r*8 +: 8];
      @(negedge clk);
    end
    g_load = 1'b0;
  endtask

  task automatic run_gens(input int cnt, input int exp_pop);
    int ndone = 0;
    int cyc   = 0;
    int prev  = 0;
    g_run = 1'b1;
    while (ndone < cnt && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (b_done) begin
        ndone++;
        check("run_pop", 64'(b_pop), 64'(exp_pop));
        if (ndone > 1) check("done_gap", 64'(cyc - prev), 64'd9);
        prev = cyc;
        if (ndone == cnt) g_run = 1'b0;
      end
    end
    g_run = 1'b0;
    check("run_count", 64'(ndone), 64'(cnt));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    a_rst = 1'b1; a_load = 1'b0; a_step = 1'b0; a_run = 1'b0;
    a_row = '0; a_data = '0; a_birth = 9'h008; a_surv = 9'h00C;
    g_rst = 1'b1; g_load = 1'b0; g_step = 1'b0; g_run = 1'b0;
    g_row = '0; g_data = '0; g_birth = 9'h008; g_surv = 9'h00C;
    repeat (2) @(negedge clk);
    a_rst = 1'b0;
    g_rst = 1'b0;

    check("rst_grid", 64'(a_grid), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_gen", 64'(a_gen), 64'd0);
    check("rst_pop", 64'(a_pop), 64'd0);

    // Blinker
    a_set(mk5(5'h00, 5'h00, 5'h0E, 5'h00, 5'h00));
    check("load_pop", 64'(a_pop), 64'd3);
    check("load_grid", 64'(a_grid),
          64'(mk5(5'h00, 5'h00, 5'h0E, 5'h00, 5'h00)));
    a_step_wait(lat);
    check("blink_lat", 64'(lat), 64'd6);
    check("blink_grid", 64'(a_grid),
          64'(mk5(5'h00, 5'h04, 5'h04, 5'h04, 5'h00)));
    check("blink_pop", 64'(a_pop), 64'd3);
    check("blink_gen", 64'(a_gen), 64'd1);
    check("blink_stable", 64'(a_stable), 64'd0);
    check("blink_busy", 64'(a_busy), 64'd0);
    a_step_wait(lat);
    check("blink2_grid", 64'(a_grid),
          64'(mk5(5'h00, 5'h00, 5'h0E, 5'h00, 5'h00)));
    check("blink2_gen", 64'(a_gen), 64'd2);
    @(negedge clk);
    check("done_pulse", 64'(a_done), 64'd0);

    // Block still life
    a_set(mk5(5'h00, 5'h06, 5'h06, 5'h00, 5'h00));
    a_step_wait(lat);
    check("block_grid", 64'(a_grid),
          64'(mk5(5'h00, 5'h06, 5'h06, 5'h00, 5'h00)));
    check("block_stable", 64'(a_stable), 64'd1);
    check("block_pop", 64'(a_pop), 64'd4);

    // Load beats step in the same idle cycle
    a_load = 1'b1; a_row = 3'd0; a_data = 5'h01; a_step = 1'b1;
    @(negedge clk);
    a_load = 1'b0; a_step = 1'b0;
    check("ldstep_busy", 64'(a_busy), 64'd0);
    check("ldstep_grid", 64'(a_grid),
          64'(mk5(5'h01, 5'h06, 5'h06, 5'h00, 5'h00)));
    check("ldstep_pop", 64'(a_pop), 64'd5);
    check("ldstep_stable", 64'(a_stable), 64'd0);
    @(negedge clk);
    check("ldstep_gen", 64'(a_gen), 64'd3);

    // Row index out of range
    a_load_row(3'd5, 5'h1F);
    check("badrow_grid", 64'(a_grid),
          64'(mk5(5'h01, 5'h06, 5'h06, 5'h00, 5'h00)));

    // B36/S23 with rule change and load attempts mid-generation
    a_set(mk5(5'h00, 5'h0E, 5'h00, 5'h0E, 5'h00));
    a_birth = 9'h048;
    a_step = 1'b1;
    @(negedge clk);
    a_step = 1'b0;
    check("b36_busy", 64'(a_busy), 64'd1);
    a_birth = 9'h008;
    a_load = 1'b1; a_row = 3'd0; a_data = 5'h1F;
    @(negedge clk);
    @(negedge clk);
    a_load = 1'b0;
    a_wait_done(lat);
    check("b36_done", 64'(a_done), 64'd1);
    check("b36_grid", 64'(a_grid),
          64'(mk5(5'h04, 5'h04, 5'h04, 5'h04, 5'h04)));
    check("b36_pop", 64'(a_pop), 64'd5);
    check("b36_gen", 64'(a_gen), 64'd4);

    // Reset while row 3 is pending
    a_step = 1'b1;
    @(negedge clk);
    a_step = 1'b0;
    repeat (3) @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    check("mrst_grid", 64'(a_grid), 64'd0);
    check("mrst_busy", 64'(a_busy), 64'd0);
    check("mrst_done", 64'(a_done), 64'd0);
    check("mrst_gen", 64'(a_gen), 64'd0);
    check("mrst_pop", 64'(a_pop), 64'd0);
    check("mrst_stable", 64'(a_stable), 64'd0);
    repeat (6) @(negedge clk);
    check("mrst_idle", 64'(a_done), 64'd0);

    // Glider on 8x8: torus returns it, bounded grid leaves a block
    g_set(64'hE080_4000_0000_0000);
    check("glider_pop", 64'(b_pop), 64'd5);
    run_gens(32, 5);
    check("torus_grid", b_grid, 64'hE080_4000_0000_0000);
    check("torus_gen", 64'(b_gen), 64'd32);
    check("torus_stable", 64'(b_stable), 64'd0);
    check("edge_grid", c_grid, 64'hC0C0_0000_0000_0000);
    check("edge_pop", 64'(c_pop), 64'd4);
    check("edge_stable", 64'(c_stable), 64'd1);

    // Empty grid to the generation counter wrap
    g_set(64'd0);
    check("empty_pop", 64'(b_pop), 64'd0);
    run_gens(32, 0);
    check("genwrap_gen", 64'(b_gen), 64'd0);
    check("genwrap_stable", 64'(b_stable), 64'd1);
    check("genwrap_pop", 64'(b_pop), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
